// File: rtl/vec_reg_file.sv
// Multi-register vector file: NUM_REGS registers of WIDTH elements, one combinational read port,
// one direct write port and a valid/ready streaming engine that loads or drains one register.
module vec_reg_file #(
    parameter int WIDTH    = 128,
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 32,
    parameter int IDX_W    = $clog2(WIDTH),
    parameter int REG_W    = $clog2(NUM_REGS)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [1:0]                rd_op,
    input  logic [REG_W-1:0]          rd_addr,
    input  logic [IDX_W-1:0]          rd_param,
    output logic [WIDTH*DATA_W-1:0]   rd_data,
    input  logic [2:0]                wr_op,
    input  logic [REG_W-1:0]          wr_addr,
    input  logic [IDX_W-1:0]          wr_param,
    input  logic [WIDTH*DATA_W-1:0]   wr_data,
    input  logic                      ld_start,
    input  logic [REG_W-1:0]          ld_addr,
    input  logic                      si_valid,
    output logic                      si_ready,
    input  logic [DATA_W-1:0]         si_data,
    input  logic                      st_start,
    input  logic [REG_W-1:0]          st_addr,
    output logic                      so_valid,
    input  logic                      so_ready,
    output logic [DATA_W-1:0]         so_data,
    output logic                      so_last,
    output logic                      busy,
    output logic                      done
);

    localparam logic [1:0] RD_VEC    = 2'd1;
    localparam logic [1:0] RD_SCALAR = 2'd2;
    localparam logic [2:0] WR_ZERO   = 3'd1;
    localparam logic [2:0] WR_VEC    = 3'd2;
    localparam logic [2:0] WR_SCALAR = 3'd3;
    localparam logic [2:0] WR_BCAST  = 3'd4;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STORE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [REG_W-1:0]   reg_q, reg_d;
    logic               done_q, done_d;
    logic [DATA_W-1:0]  mem_q [NUM_REGS][WIDTH];
    logic [DATA_W-1:0]  mem_d [NUM_REGS][WIDTH];

    logic wr_en, ld_fire, so_fire, last_idx;

    assign wr_en    = (wr_op >= WR_ZERO) && (wr_op <= WR_BCAST);
    // A direct write to the register being loaded stalls the stream for that cycle.
    assign si_ready = (state_q == ST_LOAD) && !(wr_en && (wr_addr == reg_q));
    assign so_valid = (state_q == ST_STORE);
    assign ld_fire  = si_valid && si_ready;
    assign so_fire  = so_valid && so_ready;
    assign last_idx = (idx_q == IDX_W'(WIDTH - 1));
    assign so_last  = so_valid && last_idx;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int e = 0; e < WIDTH; e++) begin
                if (rd_addr == REG_W'(r)) begin
                    if (rd_op == RD_VEC)
                        rd_data[e*DATA_W +: DATA_W] = mem_q[r][e];
                    else if (rd_op == RD_SCALAR && rd_param == IDX_W'(e))
                        rd_data[DATA_W-1:0] = mem_q[r][e];
                end
            end
        end
    end

    always_comb begin
        so_data = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (so_valid && reg_q == REG_W'(r))
                so_data = mem_q[r][idx_q];
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int e = 0; e < WIDTH; e++) begin
                if (ld_fire && reg_q == REG_W'(r) && idx_q == IDX_W'(e))
                    mem_d[r][e] = si_data;
                if (wr_en && wr_addr == REG_W'(r)) begin
                    case (wr_op)
                        WR_ZERO:   mem_d[r][e] = '0;
                        WR_VEC:    mem_d[r][e] = wr_data[e*DATA_W +: DATA_W];
                        WR_SCALAR: if (wr_param == IDX_W'(e)) mem_d[r][e] = wr_data[DATA_W-1:0];
                        WR_BCAST:  mem_d[r][e] = wr_data[DATA_W-1:0];
                        default:   ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        reg_d   = reg_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    state_d = ST_LOAD;
                    reg_d   = ld_addr;
                    idx_d   = '0;
                end else if (st_start) begin
                    state_d = ST_STORE;
                    reg_d   = st_addr;
                    idx_d   = '0;
                end
            end
            ST_LOAD, ST_STORE: begin
                if ((state_q == ST_LOAD && ld_fire) || (state_q == ST_STORE && so_fire)) begin
                    if (last_idx) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            reg_q   <= '0;
            done_q  <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            reg_q   <= reg_d;
            done_q  <= done_d;
            mem_q   <= mem_d;
        end
    end

endmodule
